main_alu: RTL and testbench
===========================

// Module: main_alu
// PURPOSE
//  Top-level 8-bit registered ALU with a 2-bit operand-control FSM. Operands num1/num2 are
//  loaded, held or cleared into registers final1/final2 under one-hot in_sel. A one-hot
//  out_sel picks one of seven ops on the registered operands. out is registered. The FSM
//  state and next state are exported for observation. Standalone block, no sub-system deps.
// PARAMETERS
//  W  8  operand/result width (all data ports sized by W)
// PORTS
//  clk        in   1  system clock, all state changes on rising edge
//  rst        in   1  asynchronous, active-low reset
//  on         in   1  enable; 0 forces OFF state
//  in_sel     in   3  one-hot: [2]=persist, [1]=load, [0]=reset
//  num1       in   W  operand A input
//  num2       in   W  operand B input
//  final1     out  W  registered operand A
//  final2     out  W  registered operand B
//  out_sel    in   7  one-hot op select (see BEHAVIOUR)
//  out        out  W  registered ALU result
//  currState  out  2  current FSM state
//  nextState  out  2  combinational next FSM state
// BEHAVIOUR
//  - Clock/reset: one clock (clk); rst async active-low. On rst=0: currState=OFF,
//    final1=final2=0, out=0.
//  - States: OFF=2'b00, CLEAR=2'b01, LOAD=2'b10, PERSIST=2'b11.
//  - nextState (combinational):
//    - on=0 -> OFF.
//    - Otherwise decode in_sel with priority reset > load > persist:
//      - [0]=1 -> CLEAR; else [1]=1 -> LOAD; else [2]=1 -> PERSIST.
//    - in_sel=000 -> hold currState, except from OFF -> CLEAR.
//  - Each rising edge: currState<=nextState, and by nextState:
//    - CLEAR: final1/2<=0.
//    - LOAD: final1<=num1, final2<=num2.
//    - PERSIST/OFF: final1/2 hold.
//  - out, registered each edge from the current final1/final2:
//    - out_sel[6] ADD  A+B (mod 2^W, carry dropped)
//    - out_sel[5] SUB  A-B (mod 2^W, two's complement)
//    - out_sel[4] AND; out_sel[3] OR; out_sel[2] XOR
//    - out_sel[1] NOT A
//    - out_sel[0] A<<1 (zero fill, MSB dropped)
//    - out_sel zero or multi-hot -> out<=0.
//    - currState==OFF or nextState==OFF -> out<=0.
//  - Latency: num -> final 1 edge; num -> out 2 edges; out_sel change -> out 1 edge.
//  - Reset mid-operation: all registers clear immediately, independent of clk.
//  - Inputs are sampled only at edges; mid-cycle changes have no effect until the next edge.
// STRUCTURE
//  - Shared package main_alu_pkg:
//    - state enum (OFF/CLEAR/LOAD/PERSIST)
//    - in_sel bit indices
//    - out_sel one-hot op constants
//  - One sub-module alu_core: combinational op decode (A, B, out_sel -> result).
//  - FSM and registers stay in main_alu.
// TESTING
//  - rst=0 pulse, clk idle -> final1/2=0, out=0, currState=00 immediately.
//  - on=1, in_sel=010, num1=0x57, num2=0x1A, out_sel=1000000:
//    - edge 1: final1=0x57, final2=0x1A, currState=LOAD.
//    - edge 2: out=0x71.
//  - Then in_sel=001 -> next edge final1/2=0, currState=CLEAR; following edge out=0x00.
//  - Load 0x02/0x04:
//    - ADD -> out=0x06
//    - SUB -> out=0xFE
//    - AND -> 0x00; OR -> 0x06; XOR -> 0x06
//    - NOT -> 0xFD
//    - SHL -> 0x04
//  - Load 0xFF/0x01, ADD -> out=0x00 (wrap); in_sel=100 with new num -> final unchanged.
//  - on=0 -> nextState=00 combinationally, out=0 next edge; in_sel=011 -> CLEAR wins;
//    out_sel=0000011 -> out=0.

Source files
------------

// File: rtl/main_alu_pkg.sv
// ============================================================================
//  Module      : main_alu_pkg
//  Description : Shared FSM encodings, in_sel bit positions and out_sel
//                one-hot opcodes for the registered ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package main_alu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_off     = 2'b00;
    localparam state_t c_st_clear   = 2'b01;
    localparam state_t c_st_load    = 2'b10;
    localparam state_t c_st_persist = 2'b11;

    localparam int c_in_sel_rst     = 0;
    localparam int c_in_sel_load    = 1;
    localparam int c_in_sel_persist = 2;

    localparam logic [6:0] c_op_add = 7'b1000000;
    localparam logic [6:0] c_op_sub = 7'b0100000;
    localparam logic [6:0] c_op_and = 7'b0010000;
    localparam logic [6:0] c_op_or  = 7'b0001000;
    localparam logic [6:0] c_op_xor = 7'b0000100;
    localparam logic [6:0] c_op_not = 7'b0000010;
    localparam logic [6:0] c_op_shl = 7'b0000001;

endpackage

`default_nettype wire

// File: rtl/main_alu_core.sv
// ============================================================================
//  Module      : alu_core
//  Description : Combinational one-hot op decode; zero or multi-hot selects
//                yield zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
    import main_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [6:0]   op_sel,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op_sel)
            c_op_add: result = a + b;
            c_op_sub: result = a - b;
            c_op_and: result = a & b;
            c_op_or:  result = a | b;
            c_op_xor: result = a ^ b;
            c_op_not: result = ~a;
            c_op_shl: result = {a[W-2:0], 1'b0};
            default:  result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/main_alu.sv
// ============================================================================
//  Module      : main_alu
//  Description : Registered W-bit ALU with a 2-bit operand-control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_alu
    import main_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         on,
    input  logic [2:0]   in_sel,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    output logic [W-1:0] final1,
    output logic [W-1:0] final2,
    input  logic [6:0]   out_sel,
    output logic [W-1:0] out,
    output logic [1:0]   currState,
    output logic [1:0]   nextState
);

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_final1;
    logic [W-1:0] r_final2;
    logic [W-1:0] r_out;
    logic [W-1:0] w_result;

    // Reset outranks load, load outranks persist; idle in_sel leaves OFF via CLEAR.
    always_comb begin
        w_next = r_state;
        if (!on) begin
            w_next = c_st_off;
        end else if (in_sel[c_in_sel_rst]) begin
            w_next = c_st_clear;
        end else if (in_sel[c_in_sel_load]) begin
            w_next = c_st_load;
        end else if (in_sel[c_in_sel_persist]) begin
            w_next = c_st_persist;
        end else if (r_state == c_st_off) begin
            w_next = c_st_clear;
        end
    end

    alu_core #(
        .W (W)
    ) u_alu_core (
        .a      (r_final1),
        .b      (r_final2),
        .op_sel (out_sel),
        .result (w_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_st_off;
            r_final1 <= '0;
            r_final2 <= '0;
            r_out    <= '0;
        end else begin
            r_state <= w_next;
            case (w_next)
                c_st_clear: begin
                    r_final1 <= '0;
                    r_final2 <= '0;
                end
                c_st_load: begin
                    r_final1 <= num1;
                    r_final2 <= num2;
                end
                default: begin
                    r_final1 <= r_final1;
                    r_final2 <= r_final2;
                end
            endcase
            // Result uses the operands held before this edge.
            if (r_state == c_st_off || w_next == c_st_off) begin
                r_out <= '0;
            end else begin
                r_out <= w_result;
            end
        end
    end

    assign final1    = r_final1;
    assign final2    = r_final2;
    assign out       = r_out;
    assign currState = r_state;
    assign nextState = w_next;

endmodule

`default_nettype wire

// File: tb/tb_main_alu.sv
// ============================================================================
//  Module      : tb_main_alu
//  Description : Self-checking bench for main_alu with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_alu;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b1;
    logic       on = 1'b0;
    logic [2:0] in_sel = 3'b000;
    logic [7:0] num1 = 8'h00;
    logic [7:0] num2 = 8'h00;
    logic [6:0] out_sel = 7'b0;
    logic [7:0] final1, final2, out;
    logic [1:0] currState, nextState;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    main_alu #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .on        (on),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .final1    (final1),
        .final2    (final2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: state names 0=OFF 1=CLEAR 2=LOAD 3=PERSIST.
    function automatic logic [1:0] model_next(input logic en, input logic [2:0] sel, input logic [1:0] st);
        if (!en)          return 2'd0;
        if (sel[0])       return 2'd1;
        if (sel[1])       return 2'd2;
        if (sel[2])       return 2'd3;
        if (st == 2'd0)   return 2'd1;
        return st;
    endfunction

    function automatic logic [7:0] model_op(input logic [7:0] a, input logic [7:0] b, input logic [6:0] sel);
        int r;
        case (sel)
            7'd64:   r = int'(a) + int'(b);
            7'd32:   r = int'(a) - int'(b) + 256;
            7'd16:   r = int'(a & b);
            7'd8:    r = int'(a | b);
            7'd4:    r = int'(a ^ b);
            7'd2:    r = 255 - int'(a);
            7'd1:    r = int'(a) * 2;
            default: r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    logic [1:0] m_state;
    logic [7:0] m_f1, m_f2, m_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= 2'd0;
            m_f1    <= 8'h00;
            m_f2    <= 8'h00;
            m_out   <= 8'h00;
        end else begin
            m_state <= model_next(on, in_sel, m_state);
            if (model_next(on, in_sel, m_state) == 2'd1) begin
                m_f1 <= 8'h00;
                m_f2 <= 8'h00;
            end else if (model_next(on, in_sel, m_state) == 2'd2) begin
                m_f1 <= num1;
                m_f2 <= num2;
            end
            if (m_state == 2'd0 || model_next(on, in_sel, m_state) == 2'd0)
                m_out <= 8'h00;
            else
                m_out <= model_op(m_f1, m_f2, out_sel);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("cmp_final1", {24'd0, final1}, {24'd0, m_f1});
            chk("cmp_final2", {24'd0, final2}, {24'd0, m_f2});
            chk("cmp_out", {24'd0, out}, {24'd0, m_out});
            chk("cmp_state", {30'd0, currState}, {30'd0, m_state});
            chk("cmp_next", {30'd0, nextState}, {30'd0, model_next(on, in_sel, m_state)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0] sel;
        logic [7:0] exp;
        string      name;
    } op_vec_t;

    op_vec_t ops[7];

    initial begin
        ops[0] = '{7'b1000000, 8'h06, "add_2_4"};
        ops[1] = '{7'b0100000, 8'hFE, "sub_2_4"};
        ops[2] = '{7'b0010000, 8'h00, "and_2_4"};
        ops[3] = '{7'b0001000, 8'h06, "or_2_4"};
        ops[4] = '{7'b0000100, 8'h06, "xor_2_4"};
        ops[5] = '{7'b0000010, 8'hFD, "not_2"};
        ops[6] = '{7'b0000001, 8'h04, "shl_2"};

        // Asynchronous reset with the clock idle.
        #2 rst = 1'b0;
        #1;
        chk("rst_final1", {24'd0, final1}, 32'h0);
        chk("rst_final2", {24'd0, final2}, 32'h0);
        chk("rst_out", {24'd0, out}, 32'h0);
        chk("rst_state", {30'd0, currState}, 32'h0);
        rst = 1'b1;

        on = 1'b1; in_sel = 3'b010; num1 = 8'h57; num2 = 8'h1A; out_sel = 7'b1000000;
        #1;
        chk_en = 1'b1;
        clk_en = 1'b1;
        tick();
        chk("load_final1", {24'd0, final1}, 32'h57);
        chk("load_final2", {24'd0, final2}, 32'h1A);
        chk("load_state", {30'd0, currState}, 32'h2);
        tick();
        chk("add_57_1a", {24'd0, out}, 32'h71);

        in_sel = 3'b001;
        tick();
        chk("clr_final1", {24'd0, final1}, 32'h0);
        chk("clr_state", {30'd0, currState}, 32'h1);
        tick();
        chk("clr_out", {24'd0, out}, 32'h0);

        in_sel = 3'b010; num1 = 8'h02; num2 = 8'h04; out_sel = 7'b1000000;
        tick();
        for (int i = 0; i < 7; i++) begin
            out_sel = ops[i].sel;
            tick();
            chk(ops[i].name, {24'd0, out}, {24'd0, ops[i].exp});
        end

        num1 = 8'hFF; num2 = 8'h01; out_sel = 7'b1000000;
        tick();
        tick();
        chk("add_wrap", {24'd0, out}, 32'h0);

        in_sel = 3'b100; num1 = 8'h33; num2 = 8'h44;
        tick();
        chk("persist_final1", {24'd0, final1}, 32'hFF);
        chk("persist_final2", {24'd0, final2}, 32'h01);
        chk("persist_state", {30'd0, currState}, 32'h3);

        on = 1'b0;
        #1;
        chk("off_next_comb", {30'd0, nextState}, 32'h0);
        tick();
        chk("off_out", {24'd0, out}, 32'h0);
        chk("off_state", {30'd0, currState}, 32'h0);

        on = 1'b1; in_sel = 3'b011;
        #1;
        chk("clear_wins", {30'd0, nextState}, 32'h1);
        tick();
        chk("clear_final2", {24'd0, final2}, 32'h0);

        in_sel = 3'b010; num1 = 8'h05; num2 = 8'h06; out_sel = 7'b0000011;
        tick();
        tick();
        chk("multihot_out", {24'd0, out}, 32'h0);

        in_sel = 3'b000;
        #1;
        chk("idle_hold", {30'd0, nextState}, 32'h2);
        tick();
        on = 1'b0;
        tick();
        on = 1'b1;
        #1;
        chk("idle_from_off", {30'd0, nextState}, 32'h1);

        in_sel = 3'b010; num1 = 8'hA5; num2 = 8'h3C; out_sel = 7'b0000100;
        tick();
        tick();
        chk("xor_a5_3c", {24'd0, out}, 32'h99);

        // Reset mid-cycle must clear everything without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("midrst_final1", {24'd0, final1}, 32'h0);
        chk("midrst_out", {24'd0, out}, 32'h0);
        chk("midrst_state", {30'd0, currState}, 32'h0);
        rst = 1'b1;
        tick();
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
